seven_seg_scan_driver: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display bank.
- Holds a hex value in a double-buffered register and decodes each nibble to the full 0-F glyph set.
- Scans digits with programmable on-time and inter-digit dead time, and applies leading-zero suppression, per-digit blanking and decimal points.
- Sits between the switch/register front end and the board display pins.

---
 rtl/seven_seg_scan_driver.sv | 211 +++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: double-buffered hex value, full 0-F glyphs,
// programmable on/dead time, leading-zero suppression, per-digit blanking and decimal points.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned ON_CYCLES      = 1000,
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned AN_ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned CNT_MAX = (ON_CYCLES > DEAD_CYCLES) ?
                                    ((ON_CYCLES > 2) ? ON_CYCLES : 2) :
                                    ((DEAD_CYCLES > 2) ? DEAD_CYCLES : 2);
  localparam int unsigned CW = $clog2(CNT_MAX);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt, idx_inc;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  frame_edge;

  logic [VW-1:0]         act_val, pend_val, view_val;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp, view_dp;
  logic [NUM_DIGITS-1:0] act_blank, pend_blank, view_blank;
  logic                  pend_flag;
  logic                  take;

  logic [3:0]            nib;
  logic                  dp_sel, blank_sel, lz_dark, lit;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            glyph_pos;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h7E;
      4'h1:    g = 7'h30;
      4'h2:    g = 7'h6D;
      4'h3:    g = 7'h79;
      4'h4:    g = 7'h33;
      4'h5:    g = 7'h5B;
      4'h6:    g = 7'h5F;
      4'h7:    g = 7'h70;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h7B;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h1F;
      4'hC:    g = 7'h4E;
      4'hD:    g = 7'h3D;
      4'hE:    g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

  assign idx_inc = (idx == IDX_LAST) ? '0 : idx + IW'(1);

  // Scan sequencing; frame_edge marks the edge that enters SHOW of digit 0.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    frame_edge = 1'b0;
    case (state)
      S_IDLE: begin
        if (cnt == '0) begin
          cnt_nxt = CW'(1);
        end else begin
          state_nxt  = S_SHOW;
          idx_nxt    = '0;
          cnt_nxt    = '0;
          frame_edge = 1'b1;
        end
      end
      S_SHOW: begin
        if (cnt == ON_LAST) begin
          cnt_nxt = '0;
          if (DEAD_CYCLES == 32'd0) begin
            idx_nxt    = idx_inc;
            frame_edge = (idx == IDX_LAST);
          end else begin
            state_nxt = S_DEAD;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DEAD: begin
        if (cnt == DEAD_LAST) begin
          state_nxt  = S_SHOW;
          idx_nxt    = idx_inc;
          cnt_nxt    = '0;
          frame_edge = (idx == IDX_LAST);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pending data becomes visible on the same edge it is promoted to active.
  assign take       = frame_edge & pend_flag;
  assign view_val   = take ? pend_val   : act_val;
  assign view_dp    = take ? pend_dp    : act_dp;
  assign view_blank = take ? pend_blank : act_blank;

  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    onehot    = '0;
    lz_dark   = lz_en && (idx_nxt != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx_nxt) begin
        nib       = view_val[4*k +: 4];
        dp_sel    = view_dp[k];
        blank_sel = view_blank[k];
        onehot[k] = 1'b1;
      end
      if ((IW'(k) >= idx_nxt) && (view_val[4*k +: 4] != 4'h0)) begin
        lz_dark = 1'b0;
      end
    end
    lit       = (state_nxt == S_SHOW);
    glyph_pos = (blank_sel || lz_dark) ? 7'h00 : glyph(nib);
    seg_nxt   = lit ? (glyph_pos ^ SEG_OFF) : SEG_OFF;
    dp_nxt    = lit ? ((dp_sel && !blank_sel && !lz_dark) ^ DP_OFF) : DP_OFF;
    an_nxt    = lit ? (onehot ^ AN_OFF) : AN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp_out      <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp_out      <= dp_nxt;
      frame_start <= frame_edge;
    end
  end

  // A load on the promotion edge lands in pending and keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
    end else begin
      if (take) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_flag  <= 1'b1;
      end else if (take) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: stimulus queues expected digit slots, a monitor reassembles lit slots
// from the pins of three differently parameterised instances and compares them in order.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: N=4 ON=4 DEAD=2
  logic        rst_a = 1'b1, load_a = 1'b0, lz_a = 1'b0;
  logic [15:0] value_a = '0;
  logic [3:0]  dp_a = '0, blank_a = '0, an_a;
  logic [6:0]  seg_a;
  logic        dpo_a, fs_a;
  // B: N=1 ON=2 DEAD=0
  logic        rst_b = 1'b1, load_b = 1'b0, lz_b = 1'b0;
  logic [3:0]  value_b = '0;
  logic [0:0]  dp_b = '0, blank_b = '0, an_b;
  logic [6:0]  seg_b;
  logic        dpo_b, fs_b;
  // C: N=4 ON=1 DEAD=0, active-low pins
  logic        rst_c = 1'b1, load_c = 1'b0, lz_c = 1'b0;
  logic [15:0] value_c = '0;
  logic [3:0]  dp_c = '0, blank_c = '0, an_c;
  logic [6:0]  seg_c;
  logic        dpo_c, fs_c;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .ON_CYCLES(4), .DEAD_CYCLES(2),
                          .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(rst_a), .value(value_a), .load(load_a), .dp_in(dp_a),
    .blank_in(blank_a), .lz_en(lz_a), .seg(seg_a), .dp_out(dpo_a), .an(an_a),
    .frame_start(fs_a));

  seven_seg_scan_driver #(.NUM_DIGITS(1), .ON_CYCLES(2), .DEAD_CYCLES(0),
                          .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_b (
    .clk(clk), .rst(rst_b), .value(value_b), .load(load_b), .dp_in(dp_b),
    .blank_in(blank_b), .lz_en(lz_b), .seg(seg_b), .dp_out(dpo_b), .an(an_b),
    .frame_start(fs_b));

  seven_seg_scan_driver #(.NUM_DIGITS(4), .ON_CYCLES(1), .DEAD_CYCLES(0),
                          .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_c (
    .clk(clk), .rst(rst_c), .value(value_c), .load(load_c), .dp_in(dp_c),
    .blank_in(blank_c), .lz_en(lz_c), .seg(seg_c), .dp_out(dpo_c), .an(an_c),
    .frame_start(fs_c));

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct {
    int         inst;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    int         len;
    int         gap;
    logic       stable;
    time        t;
    string      tag;
  } slot_t;

  slot_t q[$];
  bit    synced = 1'b0;
  int    total = 0;
  int    bad = 0;

  slot_t      cur [3];
  int         gap_cnt [3];
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp, m_fs, m_rst, m_start;

  task automatic check_slot(input slot_t s);
    slot_t e;
    if (q.size() == 0) return;
    if (q[0].inst != s.inst) return;
    if (!synced) begin
      if (s.an == q[0].an && s.fs == q[0].fs && s.t > q[0].t) synced = 1'b1;
      else return;
    end
    e = q.pop_front();
    total++;
    if (s.an !== e.an || s.seg !== e.seg || s.dp !== e.dp || s.fs !== e.fs ||
        s.len != e.len || (e.gap >= 0 && s.gap != e.gap) || s.stable !== 1'b1) begin
      bad++;
      $display("FAIL %s: an=%h seg=%h dp=%b fs=%b len=%0d gap=%0d stable=%b, required an=%h seg=%h dp=%b fs=%b len=%0d gap=%0d",
               e.tag, s.an, s.seg, s.dp, s.fs, s.len, s.gap, s.stable,
               e.an, e.seg, e.dp, e.fs, e.len, e.gap);
    end
    if (q.size() == 0) synced = 1'b0;
  endtask

  // Monitor: pins normalised to positive logic, one slot per contiguous lit digit.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin m_an = {4'b0, an_a};  m_seg = seg_a;  m_dp = dpo_a;  m_fs = fs_a; m_rst = rst_a; end
        1:       begin m_an = {7'b0, an_b};  m_seg = seg_b;  m_dp = dpo_b;  m_fs = fs_b; m_rst = rst_b; end
        default: begin m_an = {4'b0, ~an_c}; m_seg = ~seg_c; m_dp = ~dpo_c; m_fs = fs_c; m_rst = rst_c; end
      endcase
      if (m_rst) begin
        cur[i].len = 0;
        gap_cnt[i] = 0;
      end else begin
        m_start = (m_an != 8'h00) && (m_an != cur[i].an || m_fs || cur[i].len == 0);
        if (cur[i].len > 0 && (m_an == 8'h00 || m_start)) begin
          check_slot(cur[i]);
          cur[i].len = 0;
          gap_cnt[i] = 0;
        end
        if (m_start) begin
          cur[i].inst   = i;
          cur[i].an     = m_an;
          cur[i].seg    = m_seg;
          cur[i].dp     = m_dp;
          cur[i].fs     = m_fs;
          cur[i].len    = 1;
          cur[i].gap    = gap_cnt[i];
          cur[i].stable = 1'b1;
          cur[i].t      = $time;
        end else if (cur[i].len > 0) begin
          cur[i].len++;
          if (m_seg != cur[i].seg || m_dp != cur[i].dp) cur[i].stable = 1'b0;
        end else begin
          gap_cnt[i]++;
        end
      end
    end
  end

  task automatic push(input int inst, input logic [7:0] an, input logic [6:0] seg,
                      input logic dp, input logic fs, input int len, input int gap,
                      input string tag);
    slot_t e;
    e.inst = inst; e.an = an; e.seg = seg; e.dp = dp; e.fs = fs;
    e.len = len; e.gap = gap; e.stable = 1'b1; e.t = $time; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic frame4(input int inst, input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpv,
                        input int len, input int gap0, input int gapn, input string tag);
    push(inst, 8'h01, s0, dpv[0], 1'b1, len, gap0, {tag, "_d0"});
    push(inst, 8'h02, s1, dpv[1], 1'b0, len, gapn, {tag, "_d1"});
    push(inst, 8'h04, s2, dpv[2], 1'b0, len, gapn, {tag, "_d2"});
    push(inst, 8'h08, s3, dpv[3], 1'b0, len, gapn, {tag, "_d3"});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d slots unseen, required 0", tag, q.size());
      q.delete();
      synced = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", tag, act, exp);
    end
  endtask

  task automatic wait_fs_a(input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!fs_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!fs_a) begin
      total++;
      bad++;
      $display("FAIL %s: frame_start timeout, got 0, required 1", tag);
    end
  endtask

  task automatic load_a_t(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    value_a = v; dp_a = d; blank_a = b; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_a_an", 32'(an_a), 32'h0);
    chk("rst_a_seg", 32'(seg_a), 32'h0);
    chk("rst_a_dp", 32'(dpo_a), 32'h0);
    chk("rst_a_fs", 32'(fs_a), 32'h0);
    chk("rst_c_an", 32'(an_c), 32'hF);
    chk("rst_c_seg", 32'(seg_c), 32'h7F);
    chk("rst_c_dp", 32'(dpo_c), 32'h1);

    // C: inverted pins, one-clock slots, 1234
    @(negedge clk);
    rst_c = 1'b0; value_c = 16'h1234; load_c = 1'b1;
    @(negedge clk);
    load_c = 1'b0;
    frame4(2, 7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000, 1, 1, 0, "c_scan");
    frame4(2, 7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000, 1, 0, 0, "c_scan2");
    wait_drain("c_scan");

    // B: full glyph sweep, one value per frame
    @(negedge clk);
    rst_b = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      value_b = 4'(k); load_b = 1'b1;
      @(negedge clk);
      load_b = 1'b0;
      push(1, 8'h01, glyph_tab[k], 1'b0, 1'b1, 2, 0, $sformatf("glyph_%0h", k));
      wait_drain("glyph");
    end

    // A: first frames after reset, IDLE gap then 24-clock frames
    @(negedge clk);
    rst_a = 1'b0; value_a = 16'h1234; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    frame4(0, 7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000, 4, 1, 2, "a_first");
    frame4(0, 7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000, 4, 2, 2, "a_second");
    wait_drain("a_first");

    load_a_t(16'h0000, 4'b0000, 4'b0000);
    frame4(0, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b0000, 4, 2, 2, "a_zero");
    wait_drain("a_zero");

    // Mid-frame load: rest of the frame stays old, next frame is new
    wait_fs_a("dbuf_fs");
    repeat (7) @(negedge clk);
    value_a = 16'hABCD; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    push(0, 8'h04, 7'h7E, 1'b0, 1'b0, 4, 2, "dbuf_old_d2");
    push(0, 8'h08, 7'h7E, 1'b0, 1'b0, 4, 2, "dbuf_old_d3");
    frame4(0, 7'h77, 7'h1F, 7'h4E, 7'h3D, 4'b0000, 4, 2, 2, "dbuf_new");
    wait_drain("dbuf_new");

    // Two loads in one frame: only the last is shown
    wait_fs_a("dbuf2_fs");
    @(negedge clk);
    value_a = 16'h1111; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    repeat (2) @(negedge clk);
    value_a = 16'h2222; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    frame4(0, 7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'b0000, 4, 2, 2, "dbuf_last");
    wait_drain("dbuf_last");

    // Leading-zero suppression, blanking and decimal point
    @(negedge clk);
    lz_a = 1'b1;
    load_a_t(16'h0050, 4'b0001, 4'b0100);
    frame4(0, 7'h00, 7'h00, 7'h5B, 7'h7E, 4'b0001, 4, 2, 2, "lz_blank");
    wait_drain("lz_blank");
    load_a_t(16'h0000, 4'b0001, 4'b0000);
    frame4(0, 7'h00, 7'h00, 7'h00, 7'h7E, 4'b0001, 4, 2, 2, "lz_zero");
    wait_drain("lz_zero");

    // Asynchronous reset while digit 0 is lit
    @(negedge clk);
    lz_a = 1'b0;
    wait_fs_a("rst_lit_fs");
    #4;
    chk("pre_rst_lit_an", 32'(an_a), 32'h1);
    rst_a = 1'b1;
    #1;
    chk("rst_lit_an", 32'(an_a), 32'h0);
    chk("rst_lit_seg", 32'(seg_a), 32'h0);
    chk("rst_lit_dp", 32'(dpo_a), 32'h0);
    @(negedge clk);
    rst_a = 1'b0;

    // Reset during DEAD, then restart through IDLE to digit 0
    wait_fs_a("rst_dead_fs");
    repeat (4) @(posedge clk);
    #3;
    chk("dead_an", 32'(an_a), 32'h0);
    rst_a = 1'b1;
    #1;
    chk("rst_dead_an", 32'(an_a), 32'h0);
    chk("rst_dead_seg", 32'(seg_a), 32'h0);
    chk("rst_dead_fs", 32'(fs_a), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0; value_a = 16'h9876; dp_a = 4'b0000; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    frame4(0, 7'h7B, 7'h7F, 7'h70, 7'h5F, 4'b0000, 4, 1, 2, "restart");
    wait_drain("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
